// File: rtl/waterfall_pkg.sv
// Shared constants, FSM state type and address helper for the waterfall renderer.
// Optional grid overlay is enabled by defining WATERFALL_GRID_EN.
package waterfall_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 60;
  localparam int PHYS_ROWS = ROWS + 1;
  localparam int COL_SHIFT = 2;
  localparam int ROW_SHIFT = 2;
  localparam int ADDR_W    = $clog2(PHYS_ROWS * COLS);

  localparam int SLOT_W = 6;
  localparam int COL_W  = 7;
  localparam int RV_W   = 6;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PHYS_ROWS - 1);
  localparam logic [RV_W-1:0]   ROWS_MAX  = RV_W'(ROWS);

  localparam logic [23:0] GRID_RGB = 24'h404040;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAIT_VB = 2'd1,
    COMMIT  = 2'd2
  } wr_state_t;

  // slot * 80 as (slot << 6) + (slot << 4); keeps a multiplier out of the address path.
  function automatic logic [ADDR_W-1:0] row_base(input logic [SLOT_W-1:0] slot);
    logic [ADDR_W-1:0] s;
    s = {{(ADDR_W - SLOT_W){1'b0}}, slot};
    return (s << 6) + (s << 4);
  endfunction

endpackage

// File: rtl/waterfall_render_heat_colormap.sv
// Heat colormap: 8-bit magnitude to registered 24-bit {R,G,B}, one clock.
// blank forces black; grid forces the grid colour and wins over blank.
module heat_colormap
  import waterfall_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  m,
  input  logic        blank,
  input  logic        grid,
  output logic [23:0] rgb
);

  logic [7:0]  f;
  logic [23:0] color;

  // Four linear segments: black->blue, blue->cyan, cyan->yellow, yellow->red.
  always_comb begin
    f     = {m[5:0], 2'b00};
    color = 24'h000000;
    case (m[7:6])
      2'd0:    color = {8'h00, 8'h00, f};
      2'd1:    color = {8'h00, f, 8'hFF};
      2'd2:    color = {f, 8'hFF, ~f};
      default: color = {8'hFF, ~f, 8'h00};
    endcase
  end

  // Output register with overlay priority grid > blank > colour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rgb <= 24'h000000;
    end else if (grid) begin
      rgb <= GRID_RGB;
    end else if (blank) begin
      rgb <= 24'h000000;
    end else begin
      rgb <= color;
    end
  end

endmodule

// File: rtl/waterfall_render.sv
// Waterfall renderer: scrolling spectrum history in block RAM, heat-mapped per pixel.
// Write side fills a hidden slot; the row is committed on the rising edge of lower_blank.
// Read side has a fixed 3-clock latency. Defining WATERFALL_GRID_EN adds a grid overlay.
//
// Handshake: a sample transfers on every rising clk edge where sample_valid and
// sample_ready are both high; sample_ready is registered and only high in FILL.
module waterfall_render
  import waterfall_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        sample_valid,
  input  logic [7:0]  sample_data,
  output logic        sample_ready,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic        visible,
  input  logic        lower_blank,
  output logic [23:0] rgb_data,
  output logic [5:0]  rows_valid,
  output logic [1:0]  dbg_state
);

  wr_state_t         state;
  logic [COL_W-1:0]  col;
  logic [SLOT_W-1:0] wr_slot;
  logic [SLOT_W-1:0] newest;
  logic              lb_prev;
  logic              accept;
  logic [ADDR_W-1:0] wr_addr;

  logic [7:0]        ram [0:PHYS_ROWS*COLS-1];
  logic [7:0]        ram_q;

  logic [5:0]        r;
  logic [6:0]        c;
  logic [SLOT_W-1:0] slot;
  logic              mask_c;
  logic              grid_hit;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [ADDR_W-1:0] rd_addr_s0;
  logic              mask_s0;
  logic              mask_s1;
  logic              grid_s0;
  logic              grid_s1;
  logic              unused_bits;

  assign accept    = sample_valid && sample_ready;
  assign wr_addr   = row_base(wr_slot) + {{(ADDR_W - COL_W){1'b0}}, col};
  assign dbg_state = state;
  assign r         = y[7:ROW_SHIFT];
  assign c         = x[8:COL_SHIFT];
  assign unused_bits = ^{x[COL_SHIFT-1:0], y[ROW_SHIFT-1:0]};

`ifdef WATERFALL_GRID_EN
  assign grid_hit = visible && ((c[3:0] == 4'd0 && x[COL_SHIFT-1:0] == '0) || y[5:0] == 6'd0);
`else
  assign grid_hit = 1'b0;
`endif

  // Write FSM: fill the hidden slot, wait for the blanking edge, then publish it as newest.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= FILL;
      sample_ready <= 1'b0;
      col          <= '0;
      wr_slot      <= '0;
      newest       <= '0;
      rows_valid   <= '0;
      lb_prev      <= 1'b0;
    end else begin
      lb_prev <= lower_blank;
      case (state)
        FILL: begin
          if (accept && col == LAST_COL) begin
            col          <= '0;
            sample_ready <= 1'b0;
            state        <= WAIT_VB;
          end else begin
            sample_ready <= 1'b1;
            if (accept) col <= col + 7'd1;
          end
        end
        WAIT_VB: begin
          sample_ready <= 1'b0;
          if (lower_blank && !lb_prev) state <= COMMIT;
        end
        COMMIT: begin
          newest       <= wr_slot;
          wr_slot      <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + 6'd1;
          rows_valid   <= (rows_valid == ROWS_MAX) ? ROWS_MAX : rows_valid + 6'd1;
          sample_ready <= 1'b1;
          state        <= FILL;
        end
        default: begin
          sample_ready <= 1'b0;
          state        <= FILL;
        end
      endcase
    end
  end

  // S0 address math: display row r counts back from the newest slot, wrapping the ring.
  always_comb begin
    slot = '0;
    if (r <= newest) slot = newest - r;
    else             slot = newest + SLOT_W'(PHYS_ROWS) - r;
    mask_c    = !visible || (r >= rows_valid) || (r >= ROWS_MAX) || (c >= COL_W'(COLS));
    rd_addr_c = mask_c ? '0 : row_base(slot) + {{(ADDR_W - 7){1'b0}}, c};
  end

  // S0 and S1 pipeline registers; the mask and grid flags travel with the read.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_addr_s0 <= '0;
      mask_s0    <= 1'b1;
      mask_s1    <= 1'b1;
      grid_s0    <= 1'b0;
      grid_s1    <= 1'b0;
    end else begin
      rd_addr_s0 <= rd_addr_c;
      mask_s0    <= mask_c;
      mask_s1    <= mask_s0;
      grid_s0    <= grid_hit;
      grid_s1    <= grid_s0;
    end
  end

  // Block RAM: write port from the fill side, registered read port for the display (S1).
  always_ff @(posedge clk) begin
    if (accept) ram[wr_addr] <= sample_data;
    ram_q <= ram[rd_addr_s0];
  end

  heat_colormap u_cmap (
    .clk    (clk),
    .resetn (resetn),
    .m      (ram_q),
    .blank  (mask_s1),
    .grid   (grid_s1),
    .rgb    (rgb_data)
  );

endmodule

// File: tb/tb_waterfall_render.sv
// Self-checking bench for waterfall_render: randomized rows and pixel requests
// checked against a row-history model and a plain-arithmetic colormap.
module tb_waterfall_render;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sample_valid;
  logic [7:0]  sample_data;
  logic        sample_ready;
  logic [8:0]  x;
  logic [7:0]  y;
  logic        visible;
  logic        lower_blank;
  logic [23:0] rgb_data;
  logic [5:0]  rows_valid;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: hist[0] is the newest committed row, model_rv the committed-row count.
  logic [7:0]  hist [0:59][0:79];
  logic [7:0]  row_buf [0:79];
  int          model_rv = 0;

  logic [23:0] exp_q[$];
  int          tag_q[$];

  waterfall_render dut (
    .clk          (clk),
    .resetn       (resetn),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .x            (x),
    .y            (y),
    .visible      (visible),
    .lower_blank  (lower_blank),
    .rgb_data     (rgb_data),
    .rows_valid   (rows_valid),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] ref_cmap(input int m);
    int f;
    f = (m % 64) * 4;
    if (m < 64)       return {8'd0, 8'd0, 8'(f)};
    else if (m < 128) return {8'd0, 8'(f), 8'd255};
    else if (m < 192) return {8'(f), 8'd255, 8'(255 - f)};
    else              return {8'd255, 8'(255 - f), 8'd0};
  endfunction

  function automatic logic [23:0] ref_pixel(input int xx, input int yy, input bit vis);
    int rr, cc;
    if (!vis) return 24'h000000;
`ifdef WATERFALL_GRID_EN
    if ((xx % 64) == 0 || (yy % 64) == 0) return 24'h404040;
`endif
    rr = yy / 4;
    cc = xx / 4;
    if (rr >= model_rv || cc >= 80) return 24'h000000;
    return ref_cmap(int'(hist[rr][cc]));
  endfunction

  // Pixel stream: one request per clock; the result is due three clocks later.
  task automatic px(input int xx, input int yy, input bit vis, input bit push);
    logic [23:0] e;
    int t;
    @(negedge clk);
    if (exp_q.size() == 3 || (!push && exp_q.size() > 0)) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (rgb_data !== e) begin
        n_fail++;
        $display("FAIL pixel(x=%0d,y=%0d): got %h expected %h", t / 256, t % 256, rgb_data, e);
      end
    end
    if (push) begin
      x       = 9'(xx);
      y       = 8'(yy);
      visible = vis;
      exp_q.push_back(ref_pixel(xx, yy, vis));
      tag_q.push_back(xx * 256 + yy);
    end else begin
      visible = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (3) px(0, 0, 1'b0, 1'b0);
  endtask

  task automatic random_scan(input int n);
    for (int i = 0; i < n; i++) begin
      int xx, yy;
      xx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 319));
      yy = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 239));
      px(xx, yy, $urandom_range(0, 7) != 0, 1'b1);
    end
    drain();
  endtask

  task automatic fill_buf(input bit rnd, input logic [7:0] val);
    for (int i = 0; i < 80; i++) row_buf[i] = rnd ? 8'($urandom) : val;
  endtask

  // Driver: offers row_buf[0..n-1] with random idle gaps, honouring sample_ready.
  task automatic write_row(input int n);
    int idx, guard;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) != 0) begin
        sample_valid = 1'b1;
        sample_data  = row_buf[idx];
        if (sample_ready) idx++;
      end else begin
        sample_valid = 1'b0;
        sample_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    n_cmp++;
    if (idx != n) begin
      n_fail++;
      $display("FAIL write_row_timeout: accepted %0d required %0d", idx, n);
    end
  endtask

  // Pulse lower_blank and check the commit handshake and row count.
  task automatic commit_row();
    @(negedge clk);
    lower_blank = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sample_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_during_commit: got %b expected 0", sample_ready);
    end
    @(negedge clk);
    for (int i = 59; i > 0; i--) hist[i] = hist[i-1];
    for (int j = 0; j < 80; j++) hist[0][j] = row_buf[j];
    if (model_rv < 60) model_rv++;
    n_cmp++;
    if (sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_commit: got %b expected 1", sample_ready);
    end
    n_cmp++;
    if (rows_valid !== 6'(model_rv)) begin
      n_fail++;
      $display("FAIL rows_valid_after_commit: got %0d expected %0d", rows_valid, model_rv);
    end
    lower_blank = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if (rows_valid !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_rows_valid: got %0d expected 0", rows_valid);
    end
    if (rgb_data !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rgb: got %h expected 000000", rgb_data);
    end
    if (sample_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0", sample_ready);
    end
    resetn = 1'b1;
    model_rv = 0;
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    n_cmp++;
    if (sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 1", sample_ready);
    end
    for (int yy = 0; yy < 240; yy += 4)
      for (int xx = 0; xx < 320; xx += 2)
        px(xx, yy, 1'b1, 1'b1);
    drain();
    n_cmp++;
    if (rows_valid !== 6'd0) begin
      n_fail++;
      $display("FAIL empty_rows_valid: got %0d expected 0", rows_valid);
    end
  endtask

  task automatic test_first_row();
    logic [23:0] e;
    fill_buf(1'b0, 8'h40);
    write_row(80);
    commit_row();
    @(negedge clk);
    x = 9'd0; y = 8'd0; visible = 1'b1;
    repeat (3) @(posedge clk);
    #1;
`ifdef WATERFALL_GRID_EN
    e = 24'h404040;
`else
    e = 24'h0000FF;
`endif
    n_cmp++;
    if (rgb_data !== e) begin
      n_fail++;
      $display("FAIL first_row_px00: got %h expected %h", rgb_data, e);
    end
    @(negedge clk);
    x = 9'd8; y = 8'd4;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rgb_data !== 24'h000000) begin
      n_fail++;
      $display("FAIL first_row_y4_black: got %h expected 000000", rgb_data);
    end
    px(0, 0, 1'b1, 1'b1);
    px(319, 3, 1'b1, 1'b1);
    px(320, 0, 1'b1, 1'b1);
    px(5, 2, 1'b0, 1'b1);
    px(0, 239, 1'b1, 1'b1);
    random_scan(150);
  endtask

  task automatic test_two_rows();
    logic [23:0] e;
    fill_buf(1'b0, 8'hFF);
    write_row(80);
    commit_row();
    fill_buf(1'b0, 8'h80);
    write_row(80);
    commit_row();
    for (int yy = 0; yy < 8; yy++) begin
      @(negedge clk);
      x = 9'd21; y = 8'(yy); visible = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      e = (yy < 4) ? 24'h00FFFF : 24'hFF0300;
`ifdef WATERFALL_GRID_EN
      if (yy == 0) e = 24'h404040;
`endif
      n_cmp++;
      if (rgb_data !== e) begin
        n_fail++;
        $display("FAIL two_rows_y%0d: got %h expected %h", yy, rgb_data, e);
      end
    end
    random_scan(150);
  endtask

  task automatic test_stall();
    logic [1:0] st0;
    fill_buf(1'b1, 8'h00);
    @(negedge clk);
    lower_blank = 1'b1;
    write_row(80);
    st0 = dbg_state;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = 8'($urandom);
      n_cmp += 3;
      if (sample_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready: got %b expected 0", sample_ready);
      end
      if (rows_valid !== 6'(model_rv)) begin
        n_fail++;
        $display("FAIL stall_no_commit: got %0d expected %0d", rows_valid, model_rv);
      end
      if (dbg_state !== st0) begin
        n_fail++;
        $display("FAIL stall_state_held: got %0d expected %0d", dbg_state, st0);
      end
    end
    sample_valid = 1'b0;
    lower_blank  = 1'b0;
    @(negedge clk);
    commit_row();
    random_scan(200);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 65; k++) begin
      fill_buf(1'b1, 8'h00);
      write_row(80);
      commit_row();
    end
    n_cmp++;
    if (rows_valid !== 6'd60) begin
      n_fail++;
      $display("FAIL wrap_rows_valid: got %0d expected 60", rows_valid);
    end
    for (int k = 0; k < 10; k++) px(int'($urandom_range(0, 319)), 236 + int'($urandom_range(0, 3)), 1'b1, 1'b1);
    for (int rr = 0; rr < 60; rr++) px(int'($urandom_range(0, 319)), rr * 4 + int'($urandom_range(0, 3)), 1'b1, 1'b1);
    random_scan(200);
  endtask

  task automatic test_reset_mid();
    fill_buf(1'b1, 8'h00);
    write_row(40);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    model_rv = 0;
    n_cmp++;
    if (rows_valid !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_rows_valid: got %0d expected 0", rows_valid);
    end
    resetn = 1'b1;
    @(negedge clk);
    for (int yy = 0; yy < 240; yy += 8)
      for (int xx = 0; xx < 320; xx += 4)
        px(xx + int'($urandom_range(0, 3)), yy + int'($urandom_range(0, 7)), 1'b1, 1'b1);
    drain();
    fill_buf(1'b1, 8'h00);
    write_row(80);
    commit_row();
    random_scan(300);
  endtask

  // Test sequence and final report
  initial begin
    resetn       = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'h00;
    x            = 9'd0;
    y            = 8'd0;
    visible      = 1'b0;
    lower_blank  = 1'b0;
    test_reset();
    test_first_row();
    test_two_rows();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
